// File: rtl/mainmem_banked.sv
// Banked byte-lane main memory slave with a RD_LAT-deep response pipeline.
// Optional incrementing read bursts are built only when MAINMEM_BURST_EN is defined.
module mainmem_banked #(
  parameter int XLEN    = 32,
  parameter int LANES   = 4,
  parameter int DEPTH_W = 14,
  parameter int ADDR_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_wen,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [LANES-1:0]  bus_mode,
  input  logic [XLEN-1:0]   bus_dat_i,
  input  logic [3:0]        bus_burst,
  output logic [XLEN-1:0]   bus_dat_o,
  output logic              bus_ack,
  output logic              bus_err,
  output logic              bus_busy
);
  localparam int LANE_W = XLEN / LANES;
  localparam int LOG2L  = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int HI     = LOG2L + DEPTH_W;
  localparam logic [DEPTH_W-1:0] WORD_ONE = 1;

  // Handshake: a request is accepted on any posedge with bus_req=1 and bus_busy=0.
  // Every accepted request (beat) yields exactly one bus_ack pulse, in accept order,
  // sampled by the master RD_LAT edges after the accept edge.

  logic [DEPTH_W-1:0] req_idx;
  logic               req_oor;
  assign req_idx = bus_addr[LOG2L +: DEPTH_W];
  assign req_oor = (bus_addr >> HI) != '0;

  logic               acc_issue;
  logic               acc_we;
  logic               acc_err;
  logic [DEPTH_W-1:0] acc_idx;
  logic [LANES-1:0]   acc_mode;
  logic               wr_en;
  logic               unused_sig;

  assign unused_sig = ^{bus_addr, bus_burst};

`ifdef MAINMEM_BURST_EN
  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;
  state_t             state, state_nxt;
  logic [DEPTH_W-1:0] burst_word;
  logic [3:0]         burst_left;
  logic [LANES-1:0]   burst_mode;
  logic               start;

  // Out-of-range starts fall through as a single error beat.
  assign start = (state == IDLE) && bus_req && !bus_wen && !req_oor && (bus_burst != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BURST;
      BURST:   if (burst_left == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      burst_word <= '0;
      burst_left <= '0;
      burst_mode <= '0;
    end else if (start) begin
      burst_word <= req_idx + WORD_ONE;
      burst_left <= bus_burst;
      burst_mode <= bus_mode;
    end else if (state == BURST) begin
      burst_word <= burst_word + WORD_ONE;
      burst_left <= burst_left - 4'd1;
    end
  end

  always_comb begin
    bus_busy  = 1'b0;
    acc_issue = bus_req;
    acc_we    = bus_wen;
    acc_err   = req_oor;
    acc_idx   = req_idx;
    acc_mode  = bus_mode;
    if (state == BURST) begin
      bus_busy  = 1'b1;
      acc_issue = 1'b1;
      acc_we    = 1'b0;
      acc_err   = 1'b0;
      acc_idx   = burst_word;
      acc_mode  = burst_mode;
    end
  end
`else
  always_comb begin
    bus_busy  = 1'b0;
    acc_issue = bus_req;
    acc_we    = bus_wen;
    acc_err   = req_oor;
    acc_idx   = req_idx;
    acc_mode  = bus_mode;
  end
`endif

  // Writes commit at the accept edge, so a read one cycle later needs no bypass.
  assign wr_en = rst && acc_issue && acc_we && !acc_err;

  logic             s0_vld, s0_err, s0_rd;
  logic [LANES-1:0] s0_mode;
  logic [XLEN-1:0]  s0_dat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_vld  <= 1'b0;
      s0_err  <= 1'b0;
      s0_rd   <= 1'b0;
      s0_mode <= '0;
    end else begin
      s0_vld  <= acc_issue;
      s0_err  <= acc_issue && acc_err;
      s0_rd   <= acc_issue && !acc_we && !acc_err;
      s0_mode <= acc_mode;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_bank
    logic [LANE_W-1:0] mem [1 << DEPTH_W];
    logic [LANE_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && acc_mode[i]) mem[acc_idx] <= bus_dat_i[i*LANE_W +: LANE_W];
      if (acc_issue) rd_q <= mem[acc_idx];
    end

    assign s0_dat[i*LANE_W +: LANE_W] = (s0_rd && s0_mode[i]) ? rd_q : '0;
  end

  // Stage 0 is the RAM output; extra stages stretch the response to RD_LAT.
  if (RD_LAT == 1) begin : g_lat1
    assign bus_ack   = s0_vld;
    assign bus_err   = s0_err;
    assign bus_dat_o = s0_dat;
  end else begin : g_latn
    logic [RD_LAT-2:0] p_vld, p_err;
    logic [XLEN-1:0]   p_dat [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (!rst) begin
        p_vld <= '0;
        p_err <= '0;
        for (int k = 0; k < RD_LAT-1; k++) p_dat[k] <= '0;
      end else begin
        p_vld[0] <= s0_vld;
        p_err[0] <= s0_err;
        p_dat[0] <= s0_dat;
        for (int k = 1; k < RD_LAT-1; k++) begin
          p_vld[k] <= p_vld[k-1];
          p_err[k] <= p_err[k-1];
          p_dat[k] <= p_dat[k-1];
        end
      end
    end

    assign bus_ack   = p_vld[RD_LAT-2];
    assign bus_err   = p_err[RD_LAT-2];
    assign bus_dat_o = p_dat[RD_LAT-2];
  end
endmodule
